one_unit_update: RTL

- Stage directly downstream of the ONE_UNIT_MUL3 cube stage in the one-unit FastICA datapath.
- Consumes a stream of per-sample pairs: whitened z vector (4 elements) and the cube term (wTz)^3.
- Accumulates E{z·(wTz)^3} over N samples, then forms the fixed-point weight update w+ = E{z·(wTz)^3} − 3w.
- The result goes to the normalisation/orthogonalisation stage.

---
 rtl/fastica_pkg.sv | 18 +
 rtl/one_unit_mac_lane.sv | 90 +++++++++
 rtl/one_unit_update.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/fastica_pkg.sv
// Shared definitions for the one-unit FastICA datapath.
// Holds the Q12.13 sample format, Q13 constants and the update-stage state encoding.
package fastica_pkg;

    localparam int unsigned DATA_W = 26;
    localparam int unsigned FRAC   = 13;

    localparam int ONE_Q13 = 8192;
    localparam int SAT_MAX = (2 ** 25) - 1;
    localparam int SAT_MIN = -(2 ** 25);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_CALC  = 2'd2
    } upd_state_t;

endpackage : fastica_pkg

// File: rtl/one_unit_mac_lane.sv
// One element lane of the weight update: z*cube accumulator, latched weight,
// and the mean / minus-3w / saturate output register.
// Ports:
//   clk, rst_n   : clock, async active-low reset
//   i_clr        : clear the accumulator
//   i_acc_en     : accumulate i_z*i_cube this cycle
//   i_load_w     : latch i_w
//   i_calc       : register the saturated update into o_w_new
//   i_z, i_cube  : sample element and cube term (signed Q13)
//   i_w          : current weight element (signed Q13)
//   o_w_new      : updated weight element (signed Q13), held between updates
module one_unit_mac_lane
    import fastica_pkg::*;
#(
    parameter int unsigned DATA_W = fastica_pkg::DATA_W,
    parameter int unsigned FRAC   = fastica_pkg::FRAC,
    parameter int unsigned LOG2_N = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clr,
    input  logic              i_acc_en,
    input  logic              i_load_w,
    input  logic              i_calc,
    input  logic [DATA_W-1:0] i_z,
    input  logic [DATA_W-1:0] i_cube,
    input  logic [DATA_W-1:0] i_w,
    output logic [DATA_W-1:0] o_w_new
);

    localparam int unsigned PROD_W = 2 * DATA_W;
    localparam int unsigned ACC_W  = PROD_W + LOG2_N;
    localparam int unsigned SHIFT  = LOG2_N + FRAC;
    // Two guard bits above ACC_W so mean - 3w cannot wrap.
    localparam int unsigned T_W    = ACC_W + 2;

    localparam logic signed [DATA_W-1:0] OUT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] OUT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    logic signed [ACC_W-1:0]  r_acc;
    logic signed [DATA_W-1:0] r_w;
    logic signed [DATA_W-1:0] r_w_new;

    logic signed [PROD_W-1:0] w_prod;
    logic signed [ACC_W-1:0]  w_mean;
    logic signed [T_W-1:0]    w_wx;
    logic signed [T_W-1:0]    w_t;
    logic signed [DATA_W-1:0] w_sat;

    // Full-precision signed product of one sample element and the cube term.
    assign w_prod = PROD_W'($signed(i_z)) * PROD_W'($signed(i_cube));

    // Mean over N samples and removal of the Q13 scale in one floor shift.
    assign w_mean = r_acc >>> SHIFT;
    assign w_wx   = T_W'(r_w);
    assign w_t    = T_W'(w_mean) - w_wx - (w_wx <<< 1);

    // Clamp the update to the DATA_W signed range.
    always_comb begin
        w_sat = DATA_W'(w_t);
        if (w_t > T_W'(OUT_MAX)) begin
            w_sat = OUT_MAX;
        end else if (w_t < T_W'(OUT_MIN)) begin
            w_sat = OUT_MIN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc   <= '0;
            r_w     <= '0;
            r_w_new <= '0;
        end else begin
            if (i_clr) begin
                r_acc <= '0;
            end else if (i_acc_en) begin
                r_acc <= r_acc + ACC_W'(w_prod);
            end
            if (i_load_w) begin
                r_w <= $signed(i_w);
            end
            if (i_calc) begin
                r_w_new <= w_sat;
            end
        end
    end

    assign o_w_new = r_w_new;

endmodule : one_unit_mac_lane

// File: rtl/one_unit_update.sv
// FastICA one-unit weight update stage: accumulates E{z*(wTz)^3} over 2^LOG2_N
// samples and produces w+ = E{z*(wTz)^3} - 3w, saturated to DATA_W.
// Ports:
//   clk_upd, rst_n_upd : clock, async active-low reset
//   en_upd             : start / restart an update (latches w1..w4)
//   valid_in           : qualifies zi1..zi4 and cube_in
//   zi1..zi4, cube_in  : sample vector and its cube term (signed Q13)
//   w1..w4             : current weight (signed Q13), sampled on en_upd
//   busy               : accumulating or computing
//   done               : one-cycle pulse when w_new1..4 update
//   w_new1..w_new4     : updated weight (signed Q13), held until next done
module one_unit_update
    import fastica_pkg::*;
#(
    parameter int unsigned DATA_W = fastica_pkg::DATA_W,
    parameter int unsigned FRAC   = fastica_pkg::FRAC,
    parameter int unsigned LOG2_N = 10
) (
    input  logic              clk_upd,
    input  logic              rst_n_upd,
    input  logic              en_upd,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] zi1,
    input  logic [DATA_W-1:0] zi2,
    input  logic [DATA_W-1:0] zi3,
    input  logic [DATA_W-1:0] zi4,
    input  logic [DATA_W-1:0] cube_in,
    input  logic [DATA_W-1:0] w1,
    input  logic [DATA_W-1:0] w2,
    input  logic [DATA_W-1:0] w3,
    input  logic [DATA_W-1:0] w4,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] w_new1,
    output logic [DATA_W-1:0] w_new2,
    output logic [DATA_W-1:0] w_new3,
    output logic [DATA_W-1:0] w_new4
);

    localparam int unsigned LANES = 4;
    localparam int unsigned CNT_W = LOG2_N;

    upd_state_t       r_state;
    upd_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;
    logic             r_busy;
    logic             r_done;

    logic w_clr;
    logic w_load_w;
    logic w_acc_en;
    logic w_calc;

    logic [DATA_W-1:0] w_z   [LANES];
    logic [DATA_W-1:0] w_w   [LANES];
    logic [DATA_W-1:0] w_out [LANES];

    // State and sample-counter registers.
    always_ff @(posedge clk_upd or negedge rst_n_upd) begin
        if (!rst_n_upd) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
            r_done  <= w_calc;
        end
    end

    // Next-state and lane controls; en_upd restarts from any state and wins over CALC.
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_clr       = 1'b0;
        w_load_w    = 1'b0;
        w_acc_en    = 1'b0;
        w_calc      = 1'b0;

        if (en_upd) begin
            w_state_nxt = ST_ACCUM;
            w_count_nxt = '0;
            w_clr       = 1'b1;
            w_load_w    = 1'b1;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_IDLE;
                end
                ST_ACCUM: begin
                    if (valid_in) begin
                        w_acc_en    = 1'b1;
                        w_count_nxt = r_count + CNT_W'(1);
                        if (r_count == '1) begin
                            w_state_nxt = ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    w_calc      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    assign w_z[0] = zi1;
    assign w_z[1] = zi2;
    assign w_z[2] = zi3;
    assign w_z[3] = zi4;
    assign w_w[0] = w1;
    assign w_w[1] = w2;
    assign w_w[2] = w3;
    assign w_w[3] = w4;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        one_unit_mac_lane #(
            .DATA_W (DATA_W),
            .FRAC   (FRAC),
            .LOG2_N (LOG2_N)
        ) u_lane (
            .clk      (clk_upd),
            .rst_n    (rst_n_upd),
            .i_clr    (w_clr),
            .i_acc_en (w_acc_en),
            .i_load_w (w_load_w),
            .i_calc   (w_calc),
            .i_z      (w_z[g]),
            .i_cube   (cube_in),
            .i_w      (w_w[g]),
            .o_w_new  (w_out[g])
        );
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign w_new1 = w_out[0];
    assign w_new2 = w_out[1];
    assign w_new3 = w_out[2];
    assign w_new4 = w_out[3];

endmodule : one_unit_update
